// File: rtl/sys_intc.sv
// sys_intc: system registers plus a prioritised interrupt controller for the
// 16-bit pipelined core. It owns SCS/SIH/SRA/SII/SR0/SR1 and adds a mask (SIM)
// and a pending (SIP) register. It gives the pipeline one take request and a
// handler address, and serves RSR/WSR/RETI.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   irq[NINTR]         device interrupt lines, index 0 = highest priority
//   take_req / handler take request and jump target (SIH)
//   take_ack / ret_pc  pipeline redirect; return address saved into SRA
//   reti / reti_pc     RETI commit strobe and its jump target (SRA)
//   raddr / rdata      RSR read port (combinational, registered state only)
//   we/waddr/wdata     WSR write port
//
// Register map: 0 SCS {OM,CM,OIE,IE}, 1 SIH, 2 SRA, 3 SII, 4 SIM, 5 SIP,
// 6 SR0, 7 SR1.

// One pending bit. Edge mode latches a rising edge and holds it until it is
// cleared; level mode just registers the line every cycle.
module sys_intc_src #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= irq;
      // A new edge beats a clear in the same cycle.
      if (EDGE) pend <= (irq & ~irq_q) | (pend & ~clr);
      else      pend <= irq;
    end
  end
endmodule

module sys_intc #(
  parameter int               DBITS     = 16,
  parameter int               NINTR     = 4,
  parameter logic [NINTR-1:0] EDGE_MASK = {NINTR{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NINTR-1:0] irq,
  output logic             take_req,
  output logic [DBITS-1:0] handler,
  input  logic             take_ack,
  input  logic [DBITS-1:0] ret_pc,
  input  logic             reti,
  output logic [DBITS-1:0] reti_pc,
  input  logic [2:0]       raddr,
  output logic [DBITS-1:0] rdata,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [DBITS-1:0] wdata
);
  logic             ie, oie, cm, om;
  logic [DBITS-1:0] sih, sra, sii, sr0, sr1;
  logic [NINTR-1:0] sim, sip, hit, grant, clr;
  logic [DBITS-1:0] sel_idx;
  logic             ack, wsr_sip;

  assign hit   = sip & sim;
  // Isolate the lowest set bit: that is the selected source.
  assign grant = hit & (~hit + NINTR'(1));

  always_comb begin
    sel_idx = '0;
    for (int i = NINTR - 1; i >= 0; i--)
      if (hit[i]) sel_idx = DBITS'(i);
  end

  // take_req already excludes RETI, so a same-cycle ACK is dropped here.
  assign take_req = ie & (|hit) & ~reti;
  assign ack      = take_ack & take_req;
  assign handler  = sih;
  assign reti_pc  = sra;

  assign wsr_sip = we && (waddr == 3'd5);
  assign clr     = ({NINTR{ack}} & grant) | ({NINTR{wsr_sip}} & wdata[NINTR-1:0]);

  for (genvar g = 0; g < NINTR; g++) begin : g_src
    sys_intc_src #(.EDGE(EDGE_MASK[g])) u_src (
      .clk    (clk),
      .resetn (resetn),
      .irq    (irq[g]),
      .clr    (clr[g]),
      .pend   (sip[g])
    );
  end

  // SCS: take and RETI own the whole field set over a colliding WSR.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ie <= 1'b0; oie <= 1'b0; cm <= 1'b1; om <= 1'b0;
    end else if (ack) begin
      ie <= 1'b0; oie <= ie; cm <= 1'b1; om <= cm;
    end else if (reti) begin
      ie <= oie; cm <= om;
    end else if (we && waddr == 3'd0) begin
      {om, cm, oie, ie} <= wdata[3:0];
    end
  end

  // SRA/SII belong to the take path; RETI leaves them to WSR.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sra <= '0; sii <= '0;
    end else if (ack) begin
      sra <= ret_pc; sii <= sel_idx;
    end else if (we) begin
      if (waddr == 3'd2) sra <= wdata;
      if (waddr == 3'd3) sii <= wdata;
    end
  end

  // Registers no event touches: a WSR always lands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sih <= '0; sim <= '0; sr0 <= '0; sr1 <= '0;
    end else if (we) begin
      case (waddr)
        3'd1:    sih <= wdata;
        3'd4:    sim <= wdata[NINTR-1:0];
        3'd6:    sr0 <= wdata;
        3'd7:    sr1 <= wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      3'd0: rdata[3:0]       = {om, cm, oie, ie};
      3'd1: rdata            = sih;
      3'd2: rdata            = sra;
      3'd3: rdata            = sii;
      3'd4: rdata[NINTR-1:0] = sim;
      3'd5: rdata[NINTR-1:0] = sip;
      3'd6: rdata            = sr0;
      3'd7: rdata            = sr1;
      default: ;
    endcase
  end
endmodule
